// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter and its future receiver twin:
// FSM state codes, parity selectors and serial line levels.
package uart_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE   = 3'd0;
  localparam state_t START  = 3'd1;
  localparam state_t DATA   = 3'd2;
  localparam state_t PARITY = 3'd3;
  localparam state_t STOP   = 3'd4;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;

endpackage

// File: rtl/uart_tx_baud_gen.sv
// Bit-period timer: counts CLK cycles within one bit and strobes bit_end on
// the last cycle of the period, then restarts from zero.
module uart_tx_baud_gen #(
  parameter int PRESCALE_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear,
  input  logic                      enable,
  input  logic [PRESCALE_WIDTH-1:0] period,
  output logic                      bit_end
);

  logic [PRESCALE_WIDTH-1:0] count;

  // period is never zero while enabled, so period-1 cannot wrap here
  assign bit_end = enable && (count == period - PRESCALE_WIDTH'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear || bit_end) begin
      count <= '0;
    end else if (enable) begin
      count <= count + PRESCALE_WIDTH'(1);
    end
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start bit, LSB-first data, optional parity,
// one or two stop bits, with an internally generated bit period.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 8
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [DATA_WIDTH-1:0]     P_DATA,
  input  logic                      Data_Valid,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  input  logic                      STOP2,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  output logic                      busy,
  output logic                      TX_OUT
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  state_t                    state;
  state_t                    state_next;
  logic [IDX_W-1:0]          bit_idx;
  logic [IDX_W-1:0]          idx_next;
  logic                      stop_cnt;
  logic                      stop_next;
  logic [DATA_WIDTH-1:0]     data_q;
  logic                      par_en_q;
  logic                      par_bit_q;
  logic                      stop2_q;
  logic [PRESCALE_WIDTH-1:0] period_q;
  logic                      tx_q;
  logic                      tx_next;
  logic                      bit_end;
  logic                      accept;

  assign accept = Data_Valid && !busy;
  assign TX_OUT = tx_q;

  uart_tx_baud_gen #(
    .PRESCALE_WIDTH(PRESCALE_WIDTH)
  ) u_baud_gen (
    .clk    (CLK),
    .rst_n  (RST),
    .clear  (accept),
    .enable (busy),
    .period (period_q),
    .bit_end(bit_end)
  );

  // Frame settings are frozen at acceptance so later input changes cannot disturb the frame
  always_ff @(posedge CLK) begin
    if (!RST) begin
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
      period_q  <= PRESCALE_WIDTH'(1);
    end else if (accept) begin
      data_q    <= P_DATA;
      par_en_q  <= PAR_EN;
      par_bit_q <= (PAR_TYP == PAR_ODD) ? ~(^P_DATA) : (^P_DATA);
      stop2_q   <= STOP2;
      period_q  <= (Prescale == '0) ? PRESCALE_WIDTH'(1) : Prescale;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state    <= IDLE;
      bit_idx  <= '0;
      stop_cnt <= 1'b0;
      tx_q     <= LINE_IDLE;
    end else begin
      state    <= state_next;
      bit_idx  <= idx_next;
      stop_cnt <= stop_next;
      tx_q     <= tx_next;
    end
  end

  always_comb begin
    state_next = state;
    idx_next   = bit_idx;
    stop_next  = stop_cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = START;
          idx_next   = '0;
          stop_next  = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_next = DATA;
          idx_next   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx == LAST_IDX) begin
            state_next = par_en_q ? PARITY : STOP;
          end else begin
            idx_next = bit_idx + IDX_W'(1);
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_next = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (stop2_q && !stop_cnt) begin
            stop_next = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Line level is decoded from the upcoming state and registered, keeping the pad glitch-free
  always_comb begin
    busy    = (state != IDLE);
    tx_next = LINE_IDLE;
    case (state_next)
      IDLE:    tx_next = LINE_IDLE;
      START:   tx_next = LINE_START;
      DATA:    tx_next = data_q[idx_next];
      PARITY:  tx_next = par_bit_q;
      STOP:    tx_next = LINE_IDLE;
      default: tx_next = LINE_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Self-checking bench for uart_tx_param: a frame-level model checked every
// cycle, plus directed vectors with hand-computed line values.
module tb_uart_tx_param;

  localparam int DW = 8;
  localparam int PW = 8;

  logic          CLK;
  logic          RST;
  logic [DW-1:0] P_DATA;
  logic          Data_Valid;
  logic          PAR_EN;
  logic          PAR_TYP;
  logic          STOP2;
  logic [PW-1:0] Prescale;
  logic          busy;
  logic          TX_OUT;

  int checks;
  int errors;

  bit   exp_q[$];
  logic exp_tx;
  logic exp_busy;
  logic cur_busy;
  bit   model_valid;

  uart_tx_param #(
    .DATA_WIDTH    (DW),
    .PRESCALE_WIDTH(PW)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .P_DATA    (P_DATA),
    .Data_Valid(Data_Valid),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .STOP2     (STOP2),
    .Prescale  (Prescale),
    .busy      (busy),
    .TX_OUT    (TX_OUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Frame-level model: on acceptance, expand the word into its per-cycle line sequence
  always @(posedge CLK) begin
    int  p;
    bit  nb;
    bit  nt;
    if (RST !== 1'b1) begin
      exp_q.delete();
      exp_tx      <= 1'b1;
      exp_busy    <= 1'b0;
      cur_busy    <= 1'b0;
      model_valid <= 1'b1;
    end else begin
      if (!cur_busy && Data_Valid === 1'b1) begin
        p = (Prescale == 0) ? 1 : int'(Prescale);
        for (int k = 0; k < p; k++) exp_q.push_back(1'b0);
        for (int i = 0; i < DW; i++)
          for (int k = 0; k < p; k++) exp_q.push_back(P_DATA[i]);
        if (PAR_EN)
          for (int k = 0; k < p; k++) exp_q.push_back((^P_DATA) ^ PAR_TYP);
        for (int s = 0; s < (STOP2 ? 2 : 1); s++)
          for (int k = 0; k < p; k++) exp_q.push_back(1'b1);
      end
      if (exp_q.size() > 0) begin
        nt = exp_q.pop_front();
        nb = 1'b1;
      end else begin
        nt = 1'b1;
        nb = 1'b0;
      end
      exp_tx   <= nt;
      exp_busy <= nb;
      cur_busy <= nb;
    end
  end

  always @(negedge CLK) begin
    if (model_valid) begin
      checks++;
      if (TX_OUT !== exp_tx || busy !== exp_busy) begin
        errors++;
        $display("[TB] FAIL model_compare t=%0t: TX_OUT=%b busy=%b, expected TX_OUT=%b busy=%b",
                 $time, TX_OUT, busy, exp_tx, exp_busy);
      end
    end
  end

  task automatic applyStimulus(input logic [DW-1:0] d, input logic pe, input logic pt,
                               input logic s2, input logic [PW-1:0] ps);
    P_DATA     = d;
    PAR_EN     = pe;
    PAR_TYP    = pt;
    STOP2      = s2;
    Prescale   = ps;
    Data_Valid = 1'b1;
    @(negedge CLK);
    Data_Valid = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic e_tx, input logic e_busy);
    checks++;
    if (TX_OUT !== e_tx || busy !== e_busy) begin
      errors++;
      $display("[TB] FAIL %s: TX_OUT=%b busy=%b, expected TX_OUT=%b busy=%b",
               name, TX_OUT, busy, e_tx, e_busy);
    end
  endtask

  task automatic waitIdle(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (busy === 1'b0) break;
      @(negedge CLK);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s: busy=%b after %0d cycles, expected 0", name, busy, budget);
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks      = 0;
    errors      = 0;
    model_valid = 1'b0;
    RST         = 1'b0;
    Data_Valid  = 1'b0;
    P_DATA      = '0;
    PAR_EN      = 1'b0;
    PAR_TYP     = 1'b0;
    STOP2       = 1'b0;
    Prescale    = 8'd4;

    repeat (3) @(negedge CLK);
    checkOutput("reset_state", 1'b1, 1'b0);
    RST = 1'b1;
    @(negedge CLK);

    $display("[TB] test 1: 0xA5, P=4, no parity, one stop");
    applyStimulus(8'hA5, 1'b0, 1'b0, 1'b0, 8'd4);
    checkOutput("t1_start_n1", 1'b0, 1'b1);
    repeat (4) @(negedge CLK);
    checkOutput("t1_data0_n5", 1'b1, 1'b1);
    repeat (35) @(negedge CLK);
    checkOutput("t1_stop_n40", 1'b1, 1'b1);
    @(negedge CLK);
    checkOutput("t1_idle_n41", 1'b1, 1'b0);

    $display("[TB] test 2: 0xA5 with even and odd parity");
    applyStimulus(8'hA5, 1'b1, 1'b0, 1'b0, 8'd4);
    repeat (37) @(negedge CLK);
    checkOutput("t2_even_par_n38", 1'b0, 1'b1);
    repeat (7) @(negedge CLK);
    checkOutput("t2_even_idle_n45", 1'b1, 1'b0);
    applyStimulus(8'hA5, 1'b1, 1'b1, 1'b0, 8'd4);
    repeat (37) @(negedge CLK);
    checkOutput("t2_odd_par_n38", 1'b1, 1'b1);
    repeat (6) @(negedge CLK);
    checkOutput("t2_odd_stop_n44", 1'b1, 1'b1);
    @(negedge CLK);
    checkOutput("t2_odd_idle_n45", 1'b1, 1'b0);

    $display("[TB] test 3: 0xFF, Prescale=0, two stop bits");
    applyStimulus(8'hFF, 1'b0, 1'b0, 1'b1, 8'd0);
    checkOutput("t3_start_n1", 1'b0, 1'b1);
    @(negedge CLK);
    checkOutput("t3_data0_n2", 1'b1, 1'b1);
    repeat (9) @(negedge CLK);
    checkOutput("t3_stop2_n11", 1'b1, 1'b1);
    @(negedge CLK);
    checkOutput("t3_idle_n12", 1'b1, 1'b0);

    $display("[TB] test 4: request while busy and mid-frame input changes");
    applyStimulus(8'hA5, 1'b0, 1'b0, 1'b0, 8'd4);
    repeat (9) @(negedge CLK);
    P_DATA     = 8'h3C;
    Prescale   = 8'd1;
    PAR_EN     = 1'b1;
    Data_Valid = 1'b1;
    @(negedge CLK);
    Data_Valid = 1'b0;
    repeat (7) @(negedge CLK);
    checkOutput("t4_data3_n18", 1'b0, 1'b1);
    waitIdle("t4_idle", 100);

    $display("[TB] test 5: back-to-back frames");
    applyStimulus(8'h5A, 1'b0, 1'b0, 1'b0, 8'd2);
    repeat (20) @(negedge CLK);
    checkOutput("t5_gap_n21", 1'b1, 1'b0);
    applyStimulus(8'h81, 1'b0, 1'b0, 1'b0, 8'd2);
    checkOutput("t5_second_start", 1'b0, 1'b1);
    waitIdle("t5_idle", 100);

    $display("[TB] test 6: reset during data bit 3, then a fresh frame");
    applyStimulus(8'hC3, 1'b0, 1'b0, 1'b0, 8'd4);
    repeat (17) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    checkOutput("t6_after_reset", 1'b1, 1'b0);
    applyStimulus(8'h5A, 1'b1, 1'b1, 1'b0, 8'd3);
    checkOutput("t6_start", 1'b0, 1'b1);
    repeat (6) @(negedge CLK);
    checkOutput("t6_data1_m7", 1'b1, 1'b1);
    repeat (22) @(negedge CLK);
    checkOutput("t6_odd_par_m29", 1'b1, 1'b1);
    waitIdle("t6_idle", 100);

    repeat (3) @(negedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
